// File: rtl/sb_drain_receiver_if.sv
// Store-buffer drain, admission probe and 128-bit line-memory signals of sb_drain_receiver.
interface sb_drain_receiver_if;
    logic         ld_busy;
    logic         cache_ready_to_catch;
    logic         sending_data_to_cache;
    logic [63:0]  data_to_cache;
    logic [31:0]  probe_addr;
    logic         probe_hit;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack;
    logic [127:0] mem_rdata;
    logic         drain_done;

    modport master (
        output ld_busy, sending_data_to_cache, data_to_cache, probe_addr, mem_ack, mem_rdata,
        input  cache_ready_to_catch, probe_hit, mem_req, mem_we, mem_addr, mem_wdata, drain_done
    );
    modport slave (
        input  ld_busy, sending_data_to_cache, data_to_cache, probe_addr, mem_ack, mem_rdata,
        output cache_ready_to_catch, probe_hit, mem_req, mem_we, mem_addr, mem_wdata, drain_done
    );
endinterface

// File: rtl/sb_drain_receiver.sv
// Store-buffer drain receiver merging words into a direct-mapped write-back D-cache (4-word lines).
// Optional hit/miss/writeback counters when SB_DRAIN_STATS_EN is defined.
module sb_drain_receiver #(
    parameter int INDEX_BITS = 2
) (
    input  logic               clk,
    input  logic               reset,
    sb_drain_receiver_if.slave bus
`ifdef SB_DRAIN_STATS_EN
    ,
    output logic [15:0]        stat_hits,
    output logic [15:0]        stat_misses,
    output logic [15:0]        stat_writebacks
`endif
);
    localparam int NUM_LINES = 2 ** INDEX_BITS;
    localparam int TAG_W     = 28 - INDEX_BITS;

    typedef enum logic [2:0] {IDLE, WAIT_DATA, LOOKUP, WRITEBACK, FILL} state_t;
    state_t state_q, state_d;

    logic [NUM_LINES-1:0]                  valid_q, valid_d, dirty_q, dirty_d;
    logic [NUM_LINES-1:0][TAG_W-1:0]       tag_q, tag_d;
    logic [NUM_LINES-1:0][3:0][31:0]       data_q, data_d;
    logic [31:0]  pend_addr_q, pend_addr_d, pend_data_q, pend_data_d;
    logic         mem_req_q, mem_req_d, mem_we_q, mem_we_d, drain_done_q, drain_done_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [127:0] mem_wdata_q, mem_wdata_d;

    logic [INDEX_BITS-1:0] idx, probe_idx;
    logic [TAG_W-1:0]      ptag, probe_tag;
    logic [1:0]            off;
    logic                  ready, lookup_hit, victim_dirty, acked;
    logic                  unused_bits;

    assign idx          = pend_addr_q[4 +: INDEX_BITS];
    assign ptag         = pend_addr_q[31 -: TAG_W];
    assign off          = pend_addr_q[3:2];
    assign lookup_hit   = valid_q[idx] && (tag_q[idx] == ptag);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];
    assign acked        = mem_req_q && bus.mem_ack;
    assign ready        = (state_q == IDLE) && !bus.ld_busy && !reset;

    // Probe sees only installed lines; the in-flight entry stays invisible until install.
    assign probe_idx     = bus.probe_addr[4 +: INDEX_BITS];
    assign probe_tag     = bus.probe_addr[31 -: TAG_W];
    assign bus.probe_hit = valid_q[probe_idx] && (tag_q[probe_idx] == probe_tag);
    assign unused_bits   = ^{bus.probe_addr[3:0], pend_addr_q[1:0]};

    assign bus.cache_ready_to_catch = ready;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.drain_done = drain_done_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (ready) state_d = WAIT_DATA;
            WAIT_DATA: state_d = bus.sending_data_to_cache ? LOOKUP : IDLE;
            LOOKUP: begin
                if (lookup_hit)        state_d = IDLE;
                else if (victim_dirty) state_d = WRITEBACK;
                else                   state_d = FILL;
            end
            WRITEBACK: if (acked) state_d = FILL;
            FILL:      if (acked) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        drain_done_d = 1'b0;
        case (state_q)
            WAIT_DATA: if (bus.sending_data_to_cache) begin
                pend_addr_d = bus.data_to_cache[63:32];
                pend_data_d = bus.data_to_cache[31:0];
            end
            LOOKUP: if (lookup_hit) begin
                data_d[idx][off] = pend_data_q;
                dirty_d[idx]     = 1'b1;
                drain_done_d     = 1'b1;
            end
            WRITEBACK: if (acked) dirty_d[idx] = 1'b0;
            FILL: if (acked) begin
                data_d[idx]      = bus.mem_rdata;
                data_d[idx][off] = pend_data_q;
                tag_d[idx]       = ptag;
                valid_d[idx]     = 1'b1;
                dirty_d[idx]     = 1'b1;
                drain_done_d     = 1'b1;
            end
            default: ;
        endcase

        // Request is built from the next state so a same-cycle ack on state entry is valid.
        mem_req_d   = (state_d == WRITEBACK) || (state_d == FILL);
        mem_we_d    = (state_d == WRITEBACK);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == WRITEBACK) begin
            mem_addr_d  = {tag_q[idx], idx, 4'b0};
            mem_wdata_d = data_q[idx];
        end else if (state_d == FILL) begin
            mem_addr_d  = {pend_addr_q[31:4], 4'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            dirty_q      <= '0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            drain_done_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            drain_done_q <= drain_done_d;
        end
    end

    // Tags and data are masked by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef SB_DRAIN_STATS_EN
    logic [15:0] hits_q, hits_d, misses_q, misses_d, wbs_q, wbs_d;

    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        wbs_d    = wbs_q;
        if (state_q == LOOKUP && lookup_hit && hits_q != 16'hFFFF)     hits_d   = hits_q + 16'd1;
        if (state_q == LOOKUP && !lookup_hit && misses_q != 16'hFFFF)  misses_d = misses_q + 16'd1;
        if (state_q == WRITEBACK && acked && wbs_q != 16'hFFFF)        wbs_d    = wbs_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
            wbs_q    <= wbs_d;
        end
    end

    assign stat_hits       = hits_q;
    assign stat_misses     = misses_q;
    assign stat_writebacks = wbs_q;
`endif
endmodule

// File: tb/tb_sb_drain_receiver.sv
// Scoreboard bench for sb_drain_receiver: reference cache model predicts memory traffic and drain results.
module tb_sb_drain_receiver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sb_drain_receiver_if bus();
`ifdef SB_DRAIN_STATS_EN
    logic [15:0] stat_hits, stat_misses, stat_writebacks;
`endif

    sb_drain_receiver #(.INDEX_BITS(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
`ifdef SB_DRAIN_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
`endif
    );

    typedef struct { bit we; logic [31:0] addr; logic [127:0] wdata; } mem_exp_t;
    typedef struct { logic [31:0] addr; int ntxn; bit hit; } done_exp_t;
    mem_exp_t  exp_mem[$];
    done_exp_t exp_done[$];

    int n_chk = 0, n_err = 0;
    int txn_cnt = 0, req_cycles = 0, wait_cnt = 0, mem_lat = 0;
    bit hold_fill = 0;
    logic [31:0]  last_wb_addr = '0, last_fill_addr = '0;
    logic [127:0] last_wb_wdata = '0;
    logic [127:0] mem [bit [31:0]];

    bit           rv[4], rd[4];
    logic [25:0]  rt[4];
    logic [127:0] rdat[4];
`ifdef SB_DRAIN_STATS_EN
    int exp_hits = 0, exp_misses = 0, exp_wbs = 0;
`endif

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a ^ 32'hA5A5_0003, a ^ 32'h5A5A_0002, a ^ 32'h0F0F_0001, a ^ 32'hF0F0_0000};
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return rv[a[5:4]] && (rt[a[5:4]] == a[31:6]);
    endfunction

    // Reference model: decides hit/miss, queues expected memory traffic and the drain result.
    task automatic predict(input logic [31:0] a, input logic [31:0] d);
        int i = int'(a[5:4]);
        done_exp_t e;
        e.addr = a; e.hit = ref_hit(a); e.ntxn = 0;
        if (!e.hit) begin
            if (rv[i] && rd[i]) begin
                exp_mem.push_back('{1'b1, {rt[i], a[5:4], 4'h0}, rdat[i]});
                e.ntxn++;
`ifdef SB_DRAIN_STATS_EN
                exp_wbs++;
`endif
            end
            exp_mem.push_back('{1'b0, {a[31:4], 4'h0}, 128'h0});
            e.ntxn++;
            rdat[i] = mem_rd({a[31:4], 4'h0});
            rt[i] = a[31:6];
            rv[i] = 1'b1;
        end
`ifdef SB_DRAIN_STATS_EN
        if (e.hit) exp_hits++; else exp_misses++;
`endif
        rdat[i][int'(a[3:2]) * 32 +: 32] = d;
        rd[i] = 1'b1;
        exp_done.push_back(e);
    endtask

    task automatic mem_txn();
        mem_exp_t e;
        if (exp_mem.size() == 0) begin
            chk("mem_unexpected_req", {127'h0, bus.mem_req}, 128'h0);
            bus.mem_rdata = mem_rd(bus.mem_addr);
            return;
        end
        e = exp_mem.pop_front();
        chk("mem_we", {127'h0, bus.mem_we}, {127'h0, e.we});
        chk("mem_addr", {96'h0, bus.mem_addr}, {96'h0, e.addr});
        if (e.we) begin
            chk("mem_wdata", bus.mem_wdata, e.wdata);
            mem[bus.mem_addr] = bus.mem_wdata;
            last_wb_addr  = bus.mem_addr;
            last_wb_wdata = bus.mem_wdata;
        end else begin
            bus.mem_rdata  = mem_rd(bus.mem_addr);
            last_fill_addr = bus.mem_addr;
        end
        txn_cnt++;
    endtask

    // Memory responder: acks after mem_lat waiting cycles; mem_lat=0 acks in the entry cycle.
    always @(negedge clk) begin
        bus.mem_ack = 1'b0;
        if (bus.mem_req && !reset) begin
            req_cycles++;
            if (!(hold_fill && !bus.mem_we) && wait_cnt >= mem_lat) begin
                wait_cnt = 0;
                mem_txn();
                bus.mem_ack = 1'b1;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic wait_offer(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.cache_ready_to_catch) begin ok = 1'b1; break; end
        end
        if (!ok) chk("offer_timeout", {127'h0, bus.cache_ready_to_catch}, 128'h1);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sending_data_to_cache = 1'b1;
        bus.data_to_cache = {a, d};
        @(negedge clk);
        bus.sending_data_to_cache = 1'b0;
    endtask

    task automatic drain(input logic [31:0] a, input logic [31:0] d);
        bit ok;
        int t0, lat;
        done_exp_t e;
        predict(a, d);
        wait_offer(ok);
        if (!ok) return;
        t0 = txn_cnt;
        send(a, d);
        lat = 1;
        while (!bus.drain_done && lat < 100) begin @(negedge clk); lat++; end
        if (!bus.drain_done) begin chk("done_timeout", {127'h0, bus.drain_done}, 128'h1); return; end
        if (exp_done.size() == 0) begin chk("done_unexpected", {127'h0, bus.drain_done}, 128'h0); return; end
        e = exp_done.pop_front();
        chk("done_txns", txn_cnt - t0, e.ntxn);
        if (e.hit) chk("hit_latency", lat, 2);
        @(negedge clk);
        chk("done_pulse", {127'h0, bus.drain_done}, 128'h0);
    endtask

    task automatic probe(input string tag, input logic [31:0] a, input bit exp);
        bus.probe_addr = a;
        #1;
        chk(tag, {127'h0, bus.probe_hit}, {127'h0, exp});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit ok;
        int rc;
        logic [31:0] a;
        bus.ld_busy = 1'b0;
        bus.sending_data_to_cache = 1'b0;
        bus.data_to_cache = '0;
        bus.probe_addr = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 4; i++) begin rv[i] = 0; rd[i] = 0; end

        repeat (3) @(negedge clk);
        chk("rst_ready", {127'h0, bus.cache_ready_to_catch}, 128'h0);
        chk("rst_mem_req", {127'h0, bus.mem_req}, 128'h0);
        chk("rst_mem_we", {127'h0, bus.mem_we}, 128'h0);
        chk("rst_mem_addr", {96'h0, bus.mem_addr}, 128'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 128'h0);
        chk("rst_done", {127'h0, bus.drain_done}, 128'h0);
        probe("t1_probe_pre", 32'h10, 1'b0);
        reset = 1'b0;

        // Miss into an empty cache: fill only.
        drain(32'h10, 32'hDEADBEEF);
        chk("t1_fill_addr", {96'h0, last_fill_addr}, 128'h10);
        probe("t1_probe_post", 32'h10, 1'b1);

        // Hit on the same line: no memory traffic.
        rc = req_cycles;
        drain(32'h14, 32'h12345678);
        chk("t2_no_req", req_cycles - rc, 0);

        // Conflict on dirty line 1: writeback then fill, with a slow memory.
        mem_lat = 2;
        drain(32'h50, 32'hCAFEF00D);
        chk("t3_wb_addr", {96'h0, last_wb_addr}, 128'h10);
        chk("t3_wb_lo", {64'h0, last_wb_wdata[63:0]}, {64'h0, 64'h12345678_DEADBEEF});
        chk("t3_fill_addr", {96'h0, last_fill_addr}, 128'h50);
        probe("t3_probe_old", 32'h10, 1'b0);
        probe("t3_probe_new", 32'h50, 1'b1);
        mem_lat = 0;

        // Empty store buffer: offer, fall back, re-offer two cycles later.
        wait_offer(ok);
        @(negedge clk);
        chk("t4_wait_no_ready", {127'h0, bus.cache_ready_to_catch}, 128'h0);
        @(negedge clk);
        chk("t4_reoffer", {127'h0, bus.cache_ready_to_catch}, 128'h1);
        bus.ld_busy = 1'b1;
        bus.sending_data_to_cache = 1'b1;
        bus.data_to_cache = {32'h1230, 32'h0BAD_0BAD};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_idle_send_done", {127'h0, bus.drain_done}, 128'h0);
        end
        bus.sending_data_to_cache = 1'b0;
        bus.ld_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_idle_send_done2", {127'h0, bus.drain_done}, 128'h0);
        end
        probe("t4_probe", 32'h1230, 1'b0);

        // Load port owns the arrays: no offer while busy.
        @(negedge clk);
        bus.ld_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_busy_ready", {127'h0, bus.cache_ready_to_catch}, 128'h0);
            @(negedge clk);
        end
        bus.ld_busy = 1'b0;
        #1;
        chk("t5_release_ready", {127'h0, bus.cache_ready_to_catch}, 128'h1);

        // Random traffic over 4 tags x 4 lines x 4 words, low address bits included.
        for (int i = 0; i < 40; i++) begin
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            mem_lat = $urandom_range(0, 3);
            drain(a, $urandom);
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 4);
            probe("rand_probe", a, ref_hit(a));
        end

        // Evict every line so all merged data is checked on the writeback bus.
        mem_lat = 0;
        for (int i = 0; i < 4; i++) drain({26'h2AAAAAA, 2'(i), 4'h0}, 32'h600D_0000 | 32'(i));
`ifdef SB_DRAIN_STATS_EN
        chk("stat_hits", {112'h0, stat_hits}, exp_hits);
        chk("stat_misses", {112'h0, stat_misses}, exp_misses);
        chk("stat_writebacks", {112'h0, stat_writebacks}, exp_wbs);
`endif

        // Reset while a fill is outstanding abandons the entry.
        hold_fill = 1'b1;
        predict(32'h7000_0020, 32'h1111_2222);
        wait_offer(ok);
        send(32'h7000_0020, 32'h1111_2222);
        rc = 0;
        while (!(bus.mem_req && !bus.mem_we) && rc < 50) begin @(negedge clk); rc++; end
        chk("t6_in_fill", {127'h0, bus.mem_req && !bus.mem_we}, 128'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_req", {127'h0, bus.mem_req}, 128'h0);
        chk("t6_rst_done", {127'h0, bus.drain_done}, 128'h0);
        reset = 1'b0;
        hold_fill = 1'b0;
        exp_mem.delete();
        exp_done.delete();
        for (int i = 0; i < 4; i++) begin rv[i] = 0; rd[i] = 0; end
        probe("t6_probe_fill", 32'h7000_0020, 1'b0);
        probe("t6_probe_old", {26'h2AAAAAA, 2'd0, 4'h0}, 1'b0);
`ifdef SB_DRAIN_STATS_EN
        chk("t6_stat_hits", {112'h0, stat_hits}, 128'h0);
        chk("t6_stat_misses", {112'h0, stat_misses}, 128'h0);
        chk("t6_stat_wbs", {112'h0, stat_writebacks}, 128'h0);
`endif
        drain(32'h7000_0020, 32'h3333_4444);
        probe("t6_probe_refill", 32'h7000_0020, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
